// File: rtl/adder_byte_sequencer.sv
// rtl/adder_byte_sequencer.sv - byte-serial operand entry and result capture around a 32-bit adder
// Holds the button conditioner used by the panel controller, followed by the controller top.

module adder_byte_sequencer_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);
   localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // Counter only advances while the synchronised input disagrees with the accepted level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         pulse <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         pulse <= 1'b0;
         if (sync2 != level) begin
            if (cnt == CW'(DB_CYCLES - 1)) begin
               level <= sync2;
               pulse <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

module adder_byte_sequencer #(
   parameter int DB_CYCLES = 4,
   parameter int ADD_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  inp,
   input  logic        cin_sw,
   input  logic        set_btn,
   input  logic        clear_btn,
   input  logic [1:0]  select,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic        op_cin,
   input  logic [31:0] sum_in,
   input  logic        cout_in,
   output logic [7:0]  out,
   output logic        cout,
   output logic [2:0]  state_led,
   output logic        busy
);
   localparam int LW = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT);

   typedef enum logic [2:0] {
      ST_LOAD = 3'b001,
      ST_WAIT = 3'b010,
      ST_DONE = 3'b100
   } state_t;

   state_t        state, state_n;
   logic [31:0]   op_a_n, op_b_n, result_q, result_n;
   logic          op_cin_n, cout_n;
   logic [2:0]    byte_idx, byte_idx_n;
   logic [LW-1:0] lat_cnt, lat_cnt_n;
   logic          set_pulse;
   logic          clear_pulse;
   logic [31:0]   echo_word;

   adder_byte_sequencer_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (set_btn),
      .pulse (set_pulse)
   );

   adder_byte_sequencer_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (clear_btn),
      .pulse (clear_pulse)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_LOAD;
         op_a     <= '0;
         op_b     <= '0;
         op_cin   <= 1'b0;
         result_q <= '0;
         cout     <= 1'b0;
         byte_idx <= '0;
         lat_cnt  <= '0;
      end else begin
         state    <= state_n;
         op_a     <= op_a_n;
         op_b     <= op_b_n;
         op_cin   <= op_cin_n;
         result_q <= result_n;
         cout     <= cout_n;
         byte_idx <= byte_idx_n;
         lat_cnt  <= lat_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      op_a_n     = op_a;
      op_b_n     = op_b;
      op_cin_n   = op_cin;
      result_n   = result_q;
      cout_n     = cout;
      byte_idx_n = byte_idx;
      lat_cnt_n  = lat_cnt;

      case (state)
         ST_LOAD: begin
            if (set_pulse) begin
               if (byte_idx[2])
                  op_b_n[{byte_idx[1:0], 3'b000} +: 8] = inp;
               else
                  op_a_n[{byte_idx[1:0], 3'b000} +: 8] = inp;
               byte_idx_n = byte_idx + 3'd1;
               if (byte_idx == 3'd7) begin
                  op_cin_n  = cin_sw;
                  lat_cnt_n = '0;
                  state_n   = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            lat_cnt_n = lat_cnt + LW'(1);
            if (lat_cnt == LW'(ADD_LAT - 1)) begin
               result_n = sum_in;
               cout_n   = cout_in;
               state_n  = ST_DONE;
            end
         end
         ST_DONE: begin
            // Re-entry starts a new operand set but keeps untouched bytes from the previous one.
            if (set_pulse) begin
               op_a_n[7:0] = inp;
               byte_idx_n  = 3'd1;
               state_n     = ST_LOAD;
            end
         end
         default: state_n = ST_LOAD;
      endcase

      // Clear overrides anything decided above, including a capture in the same cycle.
      if (clear_pulse) begin
         state_n    = ST_LOAD;
         op_a_n     = '0;
         op_b_n     = '0;
         op_cin_n   = 1'b0;
         result_n   = '0;
         cout_n     = 1'b0;
         byte_idx_n = '0;
         lat_cnt_n  = '0;
      end
   end

   always_comb begin
      if (state == ST_DONE)
         echo_word = result_q;
      else if (byte_idx[2])
         echo_word = op_b;
      else
         echo_word = op_a;
      out = echo_word[{select, 3'b000} +: 8];
   end

   assign state_led = state;
   assign busy      = (state == ST_WAIT);
endmodule
